// File: rtl/fc_act_writeback.sv
// FC post-MAC writeback: snapshot, bias add, requantize, saturate, activate.
// Optional ReLU activation selected by FC_ACT_RELU_EN (linear when undefined).
module fc_act_writeback #(
    parameter int NUM_CH = 120,
    parameter int ACC_W  = 23,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 7,
    parameter int ADDR_W = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [NUM_CH*ACC_W-1:0] acc_bus,
    output logic                    bias_re,
    output logic [ADDR_W-1:0]       bias_addr,
    input  logic [15:0]             bias_rdata,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [OUT_W-1:0]        wr_data,
    output logic                    busy,
    output logic                    done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_CH - 1);

    localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] SAT_LO = ~SAT_HI;
    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic [1:0]              state;
    logic signed [ACC_W-1:0] snap [NUM_CH];
    logic                    p_v;
    logic [ADDR_W-1:0]       p_addr;
    logic                    accept;

    logic signed [ACC_W-1:0] acc_k;
    logic signed [ACC_W:0]   sum;
    logic signed [ACC_W:0]   q;
    logic [OUT_W-1:0]        sat;
    logic [OUT_W-1:0]        act;

    assign accept = start && (state == S_IDLE);

    // Snapshot frees the MAC bank right after start; no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NUM_CH; i++) begin
                snap[i] <= acc_bus[i*ACC_W +: ACC_W];
            end
        end
    end

    always_comb begin
        acc_k = snap[p_addr];
        sum   = {acc_k[ACC_W-1], acc_k}
              + {{(ACC_W+1-16){bias_rdata[15]}}, bias_rdata};
        q     = sum >>> SHIFT;
        sat   = q[OUT_W-1:0];
        if (q > SAT_HI) begin
            sat = OUT_MAX;
        end else if (q < SAT_LO) begin
            sat = OUT_MIN;
        end
`ifdef FC_ACT_RELU_EN
        act = sat[OUT_W-1] ? '0 : sat;
`else
        act = sat;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            bias_re   <= 1'b0;
            bias_addr <= '0;
            p_v       <= 1'b0;
            p_addr    <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            p_v    <= bias_re;
            p_addr <= bias_addr;
            wr_en  <= p_v;
            done   <= p_v && (p_addr == LAST);
            if (p_v) begin
                wr_addr <= p_addr;
                wr_data <= act;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_RUN;
                        bias_re   <= 1'b1;
                        bias_addr <= '0;
                        busy      <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (bias_addr == LAST) begin
                        bias_re <= 1'b0;
                        state   <= S_DRAIN;
                    end else begin
                        bias_addr <= bias_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Leave only after the done cycle so a coincident start is ignored.
                    if (done) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    bias_re <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_act_writeback.sv
// Scoreboard bench for fc_act_writeback: directed vectors, decoupled monitor.
// Build with or without FC_ACT_RELU_EN to match the DUT.
module tb_fc_act_writeback;

    localparam int NUM_CH = 120;
    localparam int ACC_W  = 23;
    localparam int OUT_W  = 16;
    localparam int ADDR_W = 7;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic [NUM_CH*ACC_W-1:0] acc_bus = '0;
    logic                    bias_re;
    logic [ADDR_W-1:0]       bias_addr;
    logic [15:0]             bias_rdata = '0;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [OUT_W-1:0]        wr_data;
    logic                    busy;
    logic                    done;

    fc_act_writeback dut (
        .clk(clk), .rst_n(rst_n), .start(start), .acc_bus(acc_bus),
        .bias_re(bias_re), .bias_addr(bias_addr), .bias_rdata(bias_rdata),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int acc_v [NUM_CH];
    int bias_v [NUM_CH];

    always @(posedge clk) begin
        if (bias_re) bias_rdata <= 16'(bias_v[bias_addr]);
    end

    int total = 0;
    int bad = 0;
    int exp_addr [$];
    int exp_data [$];
    int c0 = 0;
    int nwr = 0;
    int dones = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model(input int a, input int b);
        int q;
        q = (a + b) >>> 7;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
`ifdef FC_ACT_RELU_EN
        if (q < 0) q = 0;
`endif
        return q;
    endfunction

    // Monitor: pops the scoreboard on every write, checks data, order and timing.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                if (exp_addr.size() == 0) begin
                    check("unexpected_wr", int'(wr_addr), -1);
                end else begin
                    check("wr_addr", int'(wr_addr), exp_addr.pop_front());
                    check("wr_data", int'($signed(wr_data)), exp_data.pop_front());
                    check("wr_latency", cyc - c0, int'(wr_addr) + 3);
                end
                nwr++;
            end
            if (done) begin
                dones++;
                check("done_wr_en", int'(wr_en), 1);
                check("done_addr", int'(wr_addr), NUM_CH - 1);
                check("done_cycle", cyc - c0, NUM_CH + 2);
            end
        end
    end

    task automatic fill_table(input int mode);
        for (int k = 0; k < NUM_CH; k++) begin
            if (mode == 0) begin
                acc_v[k]  = k * 30011 - 1800000;
                bias_v[k] = k * 257 - 15000;
            end else begin
                acc_v[k]  = 1700000 - k * 29989;
                bias_v[k] = 12000 - k * 211;
            end
        end
        acc_v[0] = 1280;     bias_v[0] = 128;
        acc_v[5] = -1000;    bias_v[5] = 0;
        acc_v[7] = 4194303;  bias_v[7] = 32767;
        acc_v[8] = -4194304; bias_v[8] = -32768;
    endtask

    task automatic do_start();
        int e;
        @(negedge clk);
        for (int k = 0; k < NUM_CH; k++) begin
            acc_bus[k*ACC_W +: ACC_W] = ACC_W'(acc_v[k]);
            e = model(acc_v[k], bias_v[k]);
`ifdef FC_ACT_RELU_EN
            if (k == 5) e = 0;
            if (k == 8) e = 0;
`else
            if (k == 5) e = -8;
            if (k == 8) e = -32768;
`endif
            if (k == 0) e = 11;
            if (k == 7) e = 32767;
            exp_addr.push_back(k);
            exp_data.push_back(e);
        end
        start = 1'b1;
        c0 = cyc;
        nwr = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < NUM_CH + 20; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check({name, "_done_timeout"}, 0, 1);
        #1;
        check({name, "_nwr"}, nwr, NUM_CH);
        check({name, "_queue_left"}, exp_addr.size(), 0);
    endtask

    task automatic check_idle(input string name);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_wr_en"}, int'(wr_en), 0);
        check({name, "_done"}, int'(done), 0);
        check({name, "_bias_re"}, int'(bias_re), 0);
    endtask

    initial begin
        int d0;
        bit hit;
        // Reset and 20 idle cycles.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_idle("idle");
        check("idle_bias_addr", int'(bias_addr), 0);
        check("idle_wr_addr", int'(wr_addr), 0);
        check("idle_wr_data", int'(wr_data), 0);

        // Full run, then a back-to-back start in the cycle after done.
        fill_table(0);
        do_start();
        check("busy_after_start", int'(busy), 1);
        wait_done("run1");
        fill_table(1);
        do_start();
        wait_done("run2");
        @(negedge clk);
        check("run2_busy_end", int'(busy), 0);

        // acc_bus churns after start; a second start mid-run is ignored.
        fill_table(0);
        d0 = dones;
        do_start();
        fork
            begin
                repeat (NUM_CH + 10) begin
                    @(posedge clk);
                    #1 acc_bus = {NUM_CH{23'($urandom)}};
                end
            end
        join_none
        while (cyc - c0 < 50) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("run3");
        repeat (10) @(negedge clk);
        check("run3_single_done", dones - d0, 1);
        check_idle("run3_end");

        // Abort with reset at the write of ch50, then restart.
        fill_table(1);
        do_start();
        hit = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wr_en && wr_addr == 7'd50) begin
                hit = 1;
                break;
            end
        end
        check("abort_reach_ch50", int'(hit), 1);
        #1;
        rst_n = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        d0 = dones;
        repeat (3) @(negedge clk);
        check_idle("in_reset");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_idle("after_abort");
        check("abort_no_done", dones - d0, 0);
        fill_table(0);
        do_start();
        wait_done("run4");
        check("run4_one_done", dones - d0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
